// File: rtl/load_hazard_unit_pkg.sv
// Register-file geometry and hazard FSM states shared by the issue-stage units.
package load_hazard_unit_pkg;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HUNG  = 2'd2
  } hz_state_e;
endpackage

// File: rtl/load_hazard_unit_reg_match_any.sv
// Flags one register index that hits a set scoreboard bit; r0 never matches.
module reg_match_any
  import load_hazard_unit_pkg::*;
(
  input  logic                en,
  input  logic [REG_W-1:0]    idx,
  input  logic [NUM_REGS-1:0] pending,
  output logic                hit
);
  assign hit = en && (idx != '0) && pending[idx];
endmodule

// File: rtl/load_hazard_unit.sv
// Load scoreboard for the VLIW issue stage: stalls decode on RAW/WAW against
// in-flight loads, counts stall cycles and latches a hang error.
module load_hazard_unit
  import load_hazard_unit_pkg::*;
#(
  parameter int HANG_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_ixu1_rs1,
  input  logic [REG_W-1:0]    id_ixu1_rs2,
  input  logic [REG_W-1:0]    id_ixu2_rs1,
  input  logic [REG_W-1:0]    id_ixu2_rs2,
  input  logic [REG_W-1:0]    id_lsu_rs1,
  input  logic [REG_W-1:0]    id_lsu_rs2,
  input  logic [REG_W-1:0]    id_branch_rs1,
  input  logic [REG_W-1:0]    id_branch_rs2,
  input  logic [REG_W-1:0]    id_ixu1_rd,
  input  logic [REG_W-1:0]    id_ixu2_rd,
  input  logic [REG_W-1:0]    id_lsu_rd,
  input  logic                id_ixu1_nop,
  input  logic                id_ixu2_nop,
  input  logic                id_lsu_nop,
  input  logic                id_branch_nop,
  input  logic                id_lsu_is_load,
  input  logic                flush,
  input  logic                lsu_wb_load_valid,
  input  logic [REG_W-1:0]    lsu_wb_rd,
  output logic                stall,
  output logic                ex_bubble,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic                hang_err
);
  localparam int          NCHK      = 11;
  localparam logic [15:0] HANG_LIM  = HANG_LIMIT[15:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0]         r_pending;
  logic [NUM_REGS-1:0]         w_pend_nxt;
  logic [NCHK-1:0][REG_W-1:0]  w_idx;
  logic [NCHK-1:0]             w_en;
  logic [NCHK-1:0]             w_hit;
  logic                        w_hazard;
  logic                        w_set;
  hz_state_e                   r_state;
  hz_state_e                   w_state_nxt;
  logic [15:0]                 r_run_cnt;
  logic [15:0]                 w_run_nxt;
  logic [CNT_W-1:0]            r_stall_cnt;

  // Slots 0..7 are sources (branch included), 8..10 are destinations.
  assign w_idx = {id_lsu_rd, id_ixu2_rd, id_ixu1_rd,
                  id_branch_rs2, id_branch_rs1, id_lsu_rs2, id_lsu_rs1,
                  id_ixu2_rs2, id_ixu2_rs1, id_ixu1_rs2, id_ixu1_rs1};
  assign w_en  = {~id_lsu_nop, ~id_ixu2_nop, ~id_ixu1_nop,
                  {2{~id_branch_nop}}, {2{~id_lsu_nop}},
                  {2{~id_ixu2_nop}}, {2{~id_ixu1_nop}}};

  for (genvar g = 0; g < NCHK; g++) begin : g_match
    reg_match_any u_match (
      .en      (w_en[g]),
      .idx     (w_idx[g]),
      .pending (r_pending),
      .hit     (w_hit[g])
    );
  end

  assign w_hazard  = id_valid && !flush && (|w_hit);
  assign stall     = w_hazard;
  assign ex_bubble = w_hazard;
  assign pending   = r_pending;
  assign stall_cycles = r_stall_cnt;
  assign hang_err  = (r_state == HUNG);

  assign w_set = id_valid && !w_hazard && !flush && !id_lsu_nop &&
                 id_lsu_is_load && (id_lsu_rd != '0);

  // Set is applied after clear so a new load to the same register wins.
  always_comb begin
    w_pend_nxt = r_pending;
    if (lsu_wb_load_valid) w_pend_nxt[lsu_wb_rd] = 1'b0;
    if (w_set)             w_pend_nxt[id_lsu_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  assign w_run_nxt = !w_hazard ? 16'd0 :
                     (&r_run_cnt) ? r_run_cnt : (r_run_cnt + 16'd1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_hazard) w_state_nxt = STALL;
      STALL: begin
        if (!w_hazard)                  w_state_nxt = RUN;
        else if (w_run_nxt >= HANG_LIM) w_state_nxt = HUNG;
      end
      HUNG:    w_state_nxt = HUNG;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_state     <= RUN;
      r_run_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_nxt;
      if (w_hazard && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end
endmodule
